axi_prepend: RTL and testbench



---
 rtl/axi_prepend.sv | 155 +++++++++++++++
 tb/tb_axi_prepend.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_prepend.sv
// axi_prepend: AXI-stream header inserter. It places up to DATA_WIDTH header
// bytes ahead of each packet's payload and realigns the payload across beat
// boundaries. When the packet grows past its last input beat, one extra
// residue beat is emitted. Output is a single register stage.
module axi_prepend #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH*8-1:0] s_tdata,
    input  logic [DATA_WIDTH-1:0]   s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [DATA_WIDTH*8-1:0] m_tdata,
    output logic [DATA_WIDTH-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    input  logic [DATA_WIDTH*8-1:0] hdr_data,
    input  logic [LEN_WIDTH-1:0]    hdr_len
);

    localparam int DW = DATA_WIDTH;
    localparam int BW = DATA_WIDTH * 8;
    // Byte counts reach 2*DW (full header plus full last beat).
    localparam int CW = $clog2(2 * DATA_WIDTH + 1);

    typedef enum logic [1:0] {SOP, BODY, FLUSH} state_t;

    // Low n bits set; n >= DW gives all ones.
    function automatic logic [DW-1:0] keep_mask(input logic [CW-1:0] n);
        logic [DW-1:0] m;
        for (int i = 0; i < DW; i++) m[i] = (i < int'(n));
        return m;
    endfunction

    // Expand a per-byte enable into a per-bit data mask.
    function automatic logic [BW-1:0] byte_mask(input logic [DW-1:0] k);
        logic [BW-1:0] m;
        for (int i = 0; i < DW; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [DW-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DW; i++) c = c + {{(CW-1){1'b0}}, k[i]};
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   len_q, len_d;      // header length latched at SOP
    logic [CW-1:0]   flush_q, flush_d;  // valid residue bytes for the FLUSH beat
    logic [BW-1:0]   res_q, res_d;      // payload bytes pushed past the current beat
    logic            mv_d, ml_d;
    logic [BW-1:0]   md_d;
    logic [DW-1:0]   mk_d;

    logic            load;
    logic            accept;
    logic [CW-1:0]   sop_len;
    logic [CW-1:0]   cur_len;
    logic [CW-1:0]   rem_len;
    logic [CW-1:0]   total;
    logic [BW-1:0]   in_data;
    logic [BW-1:0]   head;
    logic [BW-1:0]   beat;
    logic [BW-1:0]   residue;

    // Output slot is free when empty or being drained this cycle.
    assign load     = !m_tvalid || m_tready;
    assign s_tready = (state_q != FLUSH) && load;
    assign accept   = s_tvalid && s_tready;

    assign sop_len  = (hdr_len > LEN_WIDTH'(DATA_WIDTH)) ? CW'(DATA_WIDTH) : CW'(hdr_len);
    assign cur_len  = (state_q == SOP) ? sop_len : len_q;
    assign rem_len  = CW'(DATA_WIDTH) - cur_len;
    assign total    = cur_len + popcount(s_tkeep);

    // Bytes outside tkeep are cleared so they never leak into the output.
    assign in_data  = s_tdata & byte_mask(s_tkeep);
    assign head     = (state_q == SOP) ? (hdr_data & byte_mask(keep_mask(sop_len))) : res_q;
    assign beat     = head | (in_data << {cur_len, 3'b000});
    assign residue  = in_data >> {rem_len, 3'b000};

    // Next-state and output-register load decisions.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        len_d   = len_q;
        flush_d = flush_q;
        res_d   = res_q;
        mv_d    = m_tvalid;
        md_d    = m_tdata;
        mk_d    = m_tkeep;
        ml_d    = m_tlast;

        if (load) mv_d = 1'b0;

        if (state_q == FLUSH) begin
            if (load) begin
                mv_d    = 1'b1;
                md_d    = res_q;
                mk_d    = keep_mask(flush_q);
                ml_d    = 1'b1;
                state_d = SOP;
            end
        end else if (accept) begin
            len_d = cur_len;
            res_d = residue;
            mv_d  = 1'b1;
            md_d  = beat;
            mk_d  = '1;
            ml_d  = 1'b0;
            if (!s_tlast) begin
                state_d = BODY;
            end else if (total <= CW'(DATA_WIDTH)) begin
                mk_d    = keep_mask(total);
                ml_d    = 1'b1;
                state_d = SOP;
            end else begin
                flush_d = total - CW'(DATA_WIDTH);
                state_d = FLUSH;
            end
        end
    end

    // State, residue and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the residue datapath is reset too, so outputs and FLUSH content are deterministic after reset.
        if (!rst_n) begin
            state_q  <= SOP;
            len_q    <= '0;
            flush_q  <= '0;
            res_q    <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            len_q    <= len_d;
            flush_q  <= flush_d;
            res_q    <= res_d;
            m_tvalid <= mv_d;
            m_tdata  <= md_d;
            m_tkeep  <= mk_d;
            m_tlast  <= ml_d;
        end
    end

endmodule

// File: tb/tb_axi_prepend.sv
// tb_axi_prepend: randomized and directed stimulus for axi_prepend, checked
// against a byte-stream reference model (header bytes ++ payload, re-chunked).
module tb_axi_prepend;

    localparam int DW = 8;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [63:0] hdr_data;
    logic [3:0]  hdr_len;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    rdy_mode = 0;          // 0: always ready, 1: random, 2: never ready
    int    stall_cnt = 0;
    int    first_vld_cyc = -1;
    int    first_acc_cyc = -1;
    beat_t exp_q[$];

    logic        hold_prev = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;

    axi_prepend #(.DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .hdr_data (hdr_data),
        .hdr_len  (hdr_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: header bytes followed by payload, cut into DW-byte beats.
    task automatic push_expected(input int hlen, input logic [63:0] hdr, input byte payload[$]);
        byte   stream[$];
        int    l;
        beat_t b;
        l = (hlen > DW) ? DW : hlen;
        for (int i = 0; i < l; i++) stream.push_back(byte'(hdr[8*i +: 8]));
        foreach (payload[i]) stream.push_back(payload[i]);
        for (int base = 0; base < stream.size(); base += DW) begin
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < DW && base + j < stream.size(); j++) begin
                b.data[8*j +: 8] = stream[base + j];
                b.keep[j] = 1'b1;
            end
            b.last = (base + DW >= stream.size());
            exp_q.push_back(b);
        end
    endtask

    // Sends one packet; abort_after >= 0 stops after that many beats.
    task automatic send_pkt(input int hlen, input logic [63:0] hdr, input int nbytes,
                            input bit seq, input int gap_pct, input int abort_after);
        byte payload[$];
        int  nbeats;
        int  t;
        for (int i = 0; i < nbytes; i++) payload.push_back(seq ? byte'(i) : byte'($urandom));
        push_expected(hlen, hdr, payload);
        nbeats = (nbytes + DW - 1) / DW;
        for (int b = 0; b < nbeats; b++) begin
            if (abort_after >= 0 && b == abort_after) break;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            for (int j = 0; j < DW; j++) begin
                if (b*DW + j < nbytes) begin
                    s_tdata[8*j +: 8] = payload[b*DW + j];
                    s_tkeep[j] = 1'b1;
                end else begin
                    s_tdata[8*j +: 8] = 8'($urandom);
                    s_tkeep[j] = 1'b0;
                end
            end
            s_tlast = (b == nbeats - 1);
            if (b == 0) begin
                hdr_len  = 4'(hlen);
                hdr_data = hdr;
            end
            s_tvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_tready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 1000) begin
                check("accept_timeout", 64'(t), 64'(0));
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (b == 0) begin
                first_acc_cyc = cyc;
                // Mid-packet header changes must be ignored.
                hdr_len  = 4'($urandom_range(0, 15));
                hdr_data = {$urandom, $urandom};
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(s_tready), 64'(1));
        @(posedge clk); #1;
    endtask

    // Sink-side ready generation.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_tready = (rdy_mode == 0) ? 1'b1 :
                       (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: reset values, stall stability, and scoreboard compare.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            check("rst_tvalid", 64'(m_tvalid), 64'(0));
            check("rst_tdata", m_tdata, 64'(0));
            check("rst_tkeep", 64'(m_tkeep), 64'(0));
            check("rst_tlast", 64'(m_tlast), 64'(0));
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_tvalid", 64'(m_tvalid), 64'(1));
                check("stall_tdata", m_tdata, prev_data);
                check("stall_tkeep", 64'(m_tkeep), 64'(prev_keep));
                check("stall_tlast", 64'(m_tlast), 64'(prev_last));
            end
            if (m_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (!s_tready) stall_cnt++;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("beat_tdata", m_tdata, e.data);
                    check("beat_tkeep", 64'(m_tkeep), 64'(e.keep));
                    check("beat_tlast", 64'(m_tlast), 64'(e.last));
                end
            end
            hold_prev = m_tvalid && !m_tready;
            prev_data = m_tdata;
            prev_keep = m_tkeep;
            prev_last = m_tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        hdr_data = '0;
        hdr_len  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(s_tready), 64'(1));
        check("idle_tvalid", 64'(m_tvalid), 64'(0));
        @(posedge clk); #1;

        // Pass-through: 20 bytes -> keep FF, FF, 0F; latency one cycle.
        first_vld_cyc = -1;
        stall_cnt = 0;
        send_pkt(0, 64'hFFEE_DDCC_BBAA_9988, 20, 1'b1, 0, -1);
        drain();
        check("pt_latency", 64'(first_vld_cyc), 64'(first_acc_cyc));
        check("pt_no_stall", 64'(stall_cnt), 64'(0));

        // No overflow: 3 header bytes + 13 payload bytes = exactly 2 beats.
        stall_cnt = 0;
        send_pkt(3, 64'hDEAD_BEEF_55A2_A1A0, 13, 1'b1, 0, -1);
        drain();
        check("noovf_no_stall", 64'(stall_cnt), 64'(0));

        // Overflow: 3 + 6 bytes -> full beat then FLUSH beat with 1 byte.
        stall_cnt = 0;
        send_pkt(3, 64'h1122_3344_55A2_A1A0, 6, 1'b1, 0, -1);
        drain();
        check("ovf_flush_stall", 64'(stall_cnt), 64'(1));

        // Full-beat header, and a clamped oversize header length.
        send_pkt(8, 64'h0706_0504_0302_0100, 8, 1'b0, 0, -1);
        drain();
        send_pkt(15, 64'h8786_8584_8382_8180, 8, 1'b0, 0, -1);
        drain();

        // Reset while in BODY, then a clean packet.
        rdy_mode = 0;
        send_pkt(2, {$urandom, $urandom}, 40, 1'b0, 0, 2);
        do_reset();
        send_pkt(5, {$urandom, $urandom}, 13, 1'b0, 0, -1);
        drain();

        // Reset while holding a FLUSH beat behind a stalled sink.
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_pkt(3, {$urandom, $urandom}, 6, 1'b0, 0, -1);
        @(negedge clk);
        check("flush_blocks_input", 64'(s_tready), 64'(0));
        do_reset();
        rdy_mode = 1;
        send_pkt(4, {$urandom, $urandom}, 11, 1'b0, 0, -1);
        drain();

        // Random back-to-back packets under random backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 20; p++) begin
            send_pkt(int'($urandom_range(0, 8)), {$urandom, $urandom},
                     int'($urandom_range(1, 40)), 1'b0, 30, -1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
